// File: rtl/i2c_bit_tx.sv
// i2c_bit_tx: pops serial bits (MSB-first) from an FWFT bit FIFO and drives
// them onto the I2C bus as one write burst: START, 8 data bits + ACK slot
// per byte, STOP. Stops after the byte holding the FIFO's last-bit flag, or
// after any byte the slave NACKs.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         one-clk request; accepted only in IDLE while fifo_vld=1
//   busy          high from start acceptance until the done pulse
//   done          one-clk pulse at the end of a burst
//   nack          sticky slave NACK of the last burst, cleared on acceptance
//   fifo_rd_en    one-clk pop strobe to the FIFO
//   fifo_vld      FIFO head valid
//   fifo_data     FIFO head bit
//   fifo_last     FIFO head is the last bit of the burst
//   scl_o, sda_o  open-drain line drives (1 = released, 0 = pull low)
//   sda_i         sampled SDA level, read in the ACK slot
// CLK_DIV is clk cycles per quarter SCL period; legal range 2..1023.
module i2c_bit_tx #(
    parameter int unsigned CLK_DIV = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    output logic nack,
    output logic fifo_rd_en,
    input  logic fifo_vld,
    input  logic fifo_data,
    input  logic fifo_last,
    output logic scl_o,
    output logic sda_o,
    input  logic sda_i
);

    localparam int unsigned QW = $clog2(CLK_DIV);
    localparam logic [QW-1:0] QMAX = QW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_ACK,
        S_STOP,
        S_DONE
    } state_t;

    state_t        state;
    logic [QW-1:0] qcnt;       // clk count within the current quarter
    logic [1:0]    ph;         // quarter index within the current SCL period
    logic [2:0]    bitcnt;     // data bit index within the byte
    logic          last_flag;  // last bit of the burst has been loaded
    logic          pad;        // early last seen: remaining bits of byte are 1
    logic          need_load;  // BIT entered without FIFO data: stalled
    logic          ack_smp;    // SDA level captured in the ACK slot

    logic tick;
    logic stall;
    logic enter_bit;
    logic try_load;

    // Quarter tick, stall and BIT-entry decode feeding the register block
    always_comb begin
        tick      = (qcnt == QMAX);
        stall     = (state == S_BIT) && need_load;
        enter_bit = 1'b0;
        if (tick && ph == 2'd3) begin
            if (state == S_START)
                enter_bit = 1'b1;
            if (state == S_BIT && !need_load && bitcnt != 3'd7)
                enter_bit = 1'b1;
            if (state == S_ACK && !ack_smp && !last_flag)
                enter_bit = 1'b1;
        end
        // Padded bits inside the current byte never touch the FIFO
        try_load = stall || (enter_bit && !(state == S_BIT && pad));
    end

    // Burst sequencer; line drives are updated on the edge that starts each
    // quarter so scl_o/sda_o line up with the state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            qcnt       <= '0;
            ph         <= '0;
            bitcnt     <= '0;
            last_flag  <= 1'b0;
            pad        <= 1'b0;
            need_load  <= 1'b0;
            ack_smp    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            nack       <= 1'b0;
            fifo_rd_en <= 1'b0;
            scl_o      <= 1'b1;
            sda_o      <= 1'b1;
        end else begin
            done       <= 1'b0;
            fifo_rd_en <= 1'b0;

            case (state)
                S_IDLE: begin
                    qcnt   <= '0;
                    ph     <= '0;
                    bitcnt <= '0;
                    if (start && fifo_vld) begin
                        state     <= S_START;
                        busy      <= 1'b1;
                        nack      <= 1'b0;
                        last_flag <= 1'b0;
                        pad       <= 1'b0;
                        need_load <= 1'b0;
                        ack_smp   <= 1'b0;
                        scl_o     <= 1'b1;
                        sda_o     <= 1'b1;
                    end
                end

                // ph0 idle-high, ph1 SDA falls with SCL high, ph2/3 both low
                S_START: begin
                    if (tick) begin
                        qcnt <= '0;
                        if (ph == 2'd3) begin
                            state  <= S_BIT;
                            ph     <= '0;
                            bitcnt <= '0;
                            pad    <= 1'b0;
                        end else begin
                            ph    <= ph + 2'd1;
                            scl_o <= (ph == 2'd0);
                            sda_o <= 1'b0;
                        end
                    end else begin
                        qcnt <= qcnt + QW'(1);
                    end
                end

                // SCL low in ph0/ph3, high in ph1/ph2; timer frozen while stalled
                S_BIT: begin
                    if (!need_load) begin
                        if (tick) begin
                            qcnt <= '0;
                            ph   <= ph + 2'd1;
                            if (ph == 2'd3) begin
                                scl_o <= 1'b0;
                                if (bitcnt == 3'd7) begin
                                    state <= S_ACK;
                                    sda_o <= 1'b1;
                                end else begin
                                    bitcnt <= bitcnt + 3'd1;
                                    if (pad)
                                        sda_o <= 1'b1;
                                end
                            end else begin
                                scl_o <= (ph != 2'd2);
                            end
                        end else begin
                            qcnt <= qcnt + QW'(1);
                        end
                    end
                end

                // SDA released; slave level captured at the end of ph2
                S_ACK: begin
                    if (tick) begin
                        qcnt <= '0;
                        ph   <= ph + 2'd1;
                        if (ph == 2'd2)
                            ack_smp <= sda_i;
                        if (ph == 2'd3) begin
                            scl_o <= 1'b0;
                            if (ack_smp || last_flag) begin
                                state <= S_STOP;
                                sda_o <= 1'b0;
                                if (ack_smp)
                                    nack <= 1'b1;
                            end else begin
                                state  <= S_BIT;
                                bitcnt <= '0;
                                pad    <= 1'b0;
                            end
                        end else begin
                            scl_o <= (ph != 2'd2);
                        end
                    end else begin
                        qcnt <= qcnt + QW'(1);
                    end
                end

                // ph0 both low, ph1 SCL rises, ph2/3 SDA rises with SCL high
                S_STOP: begin
                    if (tick) begin
                        qcnt <= '0;
                        if (ph == 2'd3) begin
                            state <= S_DONE;
                            ph    <= '0;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            ph    <= ph + 2'd1;
                            scl_o <= 1'b1;
                            sda_o <= (ph != 2'd0);
                        end
                    end else begin
                        qcnt <= qcnt + QW'(1);
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    qcnt  <= '0;
                    ph    <= '0;
                end

                default: state <= S_IDLE;
            endcase

            // Data load at BIT ph0 entry, retried each clk while stalled
            if (try_load) begin
                if (fifo_vld) begin
                    sda_o      <= fifo_data;
                    last_flag  <= fifo_last;
                    pad        <= fifo_last;
                    fifo_rd_en <= 1'b1;
                    need_load  <= 1'b0;
                end else begin
                    need_load  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_bit_tx.sv
// Self-checking bench for i2c_bit_tx: a queue-based FWFT FIFO, an I2C bus
// monitor that decodes START/STOP and SDA at each SCL rise, and a burst-level
// reference model of expected bits, pops, NACK and burst duration.
module tb_i2c_bit_tx;

    localparam int unsigned CD = 4;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;
    logic nack;
    logic fifo_rd_en;
    logic fifo_vld;
    logic fifo_data;
    logic fifo_last;
    logic scl_o;
    logic sda_o;
    logic sda_i;

    i2c_bit_tx #(.CLK_DIV(CD)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .nack       (nack),
        .fifo_rd_en (fifo_rd_en),
        .fifo_vld   (fifo_vld),
        .fifo_data  (fifo_data),
        .fifo_last  (fifo_last),
        .scl_o      (scl_o),
        .sda_o      (sda_o),
        .sda_i      (sda_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bit q_data[$];
    bit q_last[$];
    bit bits_q[$];
    bit nack_at[8];

    int pops, n_start, n_stop, n_done, done_cyc, acc_cyc, rises, stall_viol;
    int stall_bit = -1;
    int stall_len = 0;
    int arm = 0;
    int rem = 0;
    bit force_low = 1'b0;
    bit prev_scl = 1'b1;
    bit prev_sda = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // FIFO model, stall window, bus monitor and slave ACK driver
    always @(negedge clk) begin
        if (arm > 0) begin
            arm--;
            if (arm == 0) begin
                force_low = 1'b1;
                rem = stall_len;
            end
        end else if (force_low) begin
            if (scl_o !== 1'b0 || fifo_rd_en !== 1'b0)
                stall_viol++;
            rem--;
            if (rem == 0)
                force_low = 1'b0;
        end

        if (fifo_rd_en === 1'b1) begin
            pops++;
            if (q_data.size() > 0) begin
                q_data.delete(0);
                q_last.delete(0);
            end
            // window opens on the last clk before the stalled bit would start
            if (stall_bit > 0 && pops == stall_bit)
                arm = ((stall_bit % 8) == 0) ? 8 * CD - 1 : 4 * CD - 1;
        end

        fifo_vld  = (q_data.size() > 0) && !force_low;
        fifo_data = (q_data.size() > 0) ? q_data[0] : 1'b0;
        fifo_last = (q_last.size() > 0) ? q_last[0] : 1'b0;

        if (prev_scl && scl_o && prev_sda && !sda_o) n_start++;
        if (prev_scl && scl_o && !prev_sda && sda_o) n_stop++;
        if (!prev_scl && scl_o) begin
            bits_q.push_back(sda_o);
            rises++;
        end
        prev_scl = scl_o;
        prev_sda = sda_o;

        sda_i = (rises > 0 && rises % 9 == 0 && rises / 9 <= 8) ? nack_at[rises / 9 - 1] : 1'b1;

        if (done === 1'b1) begin
            n_done++;
            done_cyc = cyc - acc_cyc;
        end
    end

    task automatic clear_mon();
        bits_q.delete();
        pops = 0; n_start = 0; n_stop = 0; n_done = 0;
        done_cyc = -1; rises = 0; stall_viol = 0;
    endtask

    // data: bytes packed MSB-first, global bit g is data[23-g]
    task automatic run_burst(input string tag, input logic [23:0] data, input int last_idx,
                             input logic [2:0] nk, input int sbit, input int slen);
        int nb_end, nbytes, exp_pops, exp_cyc, exp_len, budget, g;
        bit found, stall_on, e;
        logic [31:0] exp_v, got_v;
        nb_end = last_idx / 8;
        found = 1'b0;
        for (int b = 0; b <= last_idx / 8; b++) begin
            if (!found && nk[b]) begin
                nb_end = b;
                found = 1'b1;
            end
        end
        nbytes   = nb_end + 1;
        exp_pops = (last_idx + 1 < 8 * nbytes) ? last_idx + 1 : 8 * nbytes;
        stall_on = (sbit >= 1) && (sbit <= last_idx) && (sbit < 8 * nbytes);
        exp_cyc  = (8 + 36 * nbytes) * CD + (stall_on ? slen : 0);
        // data bits (1 after last), released ACK bit, then the STOP's SCL rise with SDA low
        exp_v = '0;
        for (int b = 0; b < nbytes; b++) begin
            for (int i = 0; i < 8; i++) begin
                g = 8 * b + i;
                e = (g <= last_idx) ? data[23 - g] : 1'b1;
                exp_v = {exp_v[30:0], e};
            end
            exp_v = {exp_v[30:0], 1'b1};
        end
        exp_v   = {exp_v[30:0], 1'b0};
        exp_len = 9 * nbytes + 1;

        clear_mon();
        for (int i = 0; i < 8; i++) nack_at[i] = (i < 3) ? nk[i] : 1'b0;
        stall_bit = stall_on ? sbit : -1;
        stall_len = slen;
        q_data.delete();
        q_last.delete();
        for (int i = 0; i <= last_idx; i++) begin
            q_data.push_back(data[23 - i]);
            q_last.push_back(i == last_idx);
        end

        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc_cyc = cyc;
        chk({tag, "_acc_busy"}, 32'(busy), 32'd1);
        chk({tag, "_acc_nack"}, 32'(nack), 32'd0);

        // a start while busy must not restart the burst
        repeat (30) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        budget = exp_cyc + 200;
        while (n_done == 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk({tag, "_done_seen"}, 32'(n_done > 0), 32'd1);
        chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(exp_cyc));
        repeat (4) @(negedge clk);

        got_v = '0;
        foreach (bits_q[i]) got_v = {got_v[30:0], bits_q[i]};
        chk({tag, "_done_cnt"}, 32'(n_done), 32'd1);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_bus_idle"}, {30'd0, scl_o, sda_o}, 32'd3);
        chk({tag, "_nack"}, 32'(nack), 32'(nk[nb_end]));
        chk({tag, "_pops"}, 32'(pops), 32'(exp_pops));
        chk({tag, "_starts"}, 32'(n_start), 32'd1);
        chk({tag, "_stops"}, 32'(n_stop), 32'd1);
        chk({tag, "_nbits"}, 32'(rises), 32'(exp_len));
        chk({tag, "_bits"}, got_v, exp_v);
        if (stall_on)
            chk({tag, "_stall_hold"}, 32'(stall_viol), 32'd0);

        stall_bit = -1;
        arm = 0;
        force_low = 1'b0;
        q_data.delete();
        q_last.delete();
    endtask

    task automatic reset_test();
        clear_mon();
        for (int i = 0; i < 8; i++) nack_at[i] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            q_data.push_back(i % 2 == 0);
            q_last.push_back(i == 7);
        end
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc_cyc = cyc;
        // bit 5 spans clks 96..111 after acceptance
        repeat (100) @(negedge clk);
        chk("rst_pops_before", 32'(pops), 32'd6);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_lines", {30'd0, scl_o, sda_o}, 32'd3);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_no_done", 32'(n_done), 32'd0);
        chk("rst_no_pop", 32'(pops), 32'd6);
        q_data.delete();
        q_last.delete();
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("novld_busy", 32'(busy), 32'd0);
        repeat (300) @(negedge clk);
        chk("novld_no_done", 32'(n_done), 32'd0);
        chk("novld_lines", {30'd0, scl_o, sda_o}, 32'd3);
    endtask

    initial begin
        logic [23:0] rdata;
        logic [2:0]  rnk;
        int          rlast, rsbit, rslen, rbytes;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_lines", {30'd0, scl_o, sda_o}, 32'd3);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_nack", 32'(nack), 32'd0);
        chk("reset_rd_en", 32'(fifo_rd_en), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_burst("a5", 24'hA50000, 7, 3'b000, -1, 0);
        run_burst("3cff", 24'h3CFF00, 15, 3'b000, -1, 0);
        run_burst("a5nk", 24'hA50000, 7, 3'b001, -1, 0);
        repeat (10) @(negedge clk);
        chk("nack_held", 32'(nack), 32'd1);
        run_burst("clr", 24'h5A0000, 7, 3'b000, -1, 0);
        run_burst("stall", 24'hA50000, 7, 3'b000, 3, 50);
        run_burst("b0", 24'hB00000, 4, 3'b000, -1, 0);
        reset_test();

        for (int n = 0; n < 12; n++) begin
            rbytes = $urandom_range(1, 3);
            rdata  = 24'($urandom);
            rlast  = $urandom_range(0, 8 * rbytes - 1);
            for (int b = 0; b < 3; b++) rnk[b] = ($urandom_range(0, 3) == 0);
            rsbit = -1;
            rslen = 0;
            if ($urandom_range(0, 1) == 1 && rlast >= 1) begin
                rsbit = $urandom_range(1, rlast);
                rslen = $urandom_range(1, 40);
            end
            run_burst($sformatf("rnd%0d", n), rdata, rlast, rnk, rsbit, rslen);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
